ro_race_counter: RTL and testbench

- N-channel oscillator race counter: counts rising edges of N asynchronous oscillator inputs over a fixed clock window, then reports per-channel counts and the fastest channel.
- Single clock domain; oscillator inputs are synchronised, not used as clocks.
- Sits between the ring-oscillator array and response/ID logic as the multi-channel, windowed replacement for the two-counter race block.

---
 rtl/ro_race_pkg.sv | 24 ++
 rtl/ro_edge_counter.sv | 52 +++++
 rtl/ro_race_counter.sv | 152 +++++++++++++++
 tb/tb_ro_race_counter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_race_pkg.sv
// Shared types and constants for the ro_race_counter oscillator race block.
package ro_race_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CMP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEF_N             = 4;
   localparam int DEF_WIDTH         = 8;
   localparam int DEF_WINDOW_CYCLES = 1000;

   // Bits needed to index `value` items; at least 1 so single-bit ports stay legal.
   function automatic int ro_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One oscillator channel: 2-flop synchroniser, rising-edge detect and a
// saturating counter that never wraps past all-ones.
module ro_edge_counter
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             osc,
   input  logic             clear,
   input  logic             count_en,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             hit_max
);

   localparam logic [WIDTH-1:0] ALMOST_MAX = {{(WIDTH-1){1'b1}}, 1'b0};

   logic sync0;
   logic sync1;
   logic edge_q;
   logic rise;

   // edge_q always tracks sync1, so a clear leaves it preloaded with the
   // current level and a steady-high input never looks like an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync0  <= 1'b0;
         sync1  <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sync0  <= osc;
         sync1  <= sync0;
         edge_q <= sync1;
      end
   end

   assign rise    = sync1 & ~edge_q;
   assign at_max  = &count;
   assign hit_max = count_en & rise & (count == ALMOST_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && rise && !at_max) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ro_race_counter.sv
// N-channel windowed oscillator race counter with winner select.
// Optional pairwise response bits are built when RO_PAIR_RESPONSE_EN is defined.
module ro_race_counter
   import ro_race_pkg::*;
#(
   parameter int N             = DEF_N,
   parameter int WIDTH         = DEF_WIDTH,
   parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N-1:0]             osc_in,
   input  logic                     start,
   input  logic                     enable,
   output logic                     busy,
   output logic                     done,
   output logic                     saturated,
   output logic [N*WIDTH-1:0]       counts,
   output logic [ro_clog2(N)-1:0]   winner,
   output logic [N/2-1:0]           response,
   output state_t                   fsm_state
);

   localparam int WIN_W   = ro_clog2(N);
   localparam int TIMER_W = ro_clog2(WINDOW_CYCLES + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);

   state_t             state;
   state_t             state_next;
   logic               clear_all;
   logic               count_en;
   logic [TIMER_W-1:0] timer;
   logic [N-1:0]       at_max;
   logic [N-1:0]       hit_max;
   logic               hit_any;
   logic               max_any;
   logic [WIDTH-1:0]   count_arr [N];
   logic [WIN_W-1:0]   best_idx;
   logic [WIDTH-1:0]   best_val;
   logic               done_q;

   for (genvar i = 0; i < N; i++) begin : g_ch
      ro_edge_counter #(.WIDTH(WIDTH)) u_ch (
         .clk      (clk),
         .reset_n  (reset_n),
         .osc      (osc_in[i]),
         .clear    (clear_all),
         .count_en (count_en),
         .count    (count_arr[i]),
         .at_max   (at_max[i]),
         .hit_max  (hit_max[i])
      );
      assign counts[i*WIDTH +: WIDTH] = count_arr[i];
   end

   assign hit_any = |hit_max;
   assign max_any = |at_max;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      clear_all  = 1'b0;
      count_en   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               clear_all  = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (max_any) begin
               state_next = CMP;
            end else if (enable) begin
               // The exit cycle still counts, so the window is exactly WINDOW_CYCLES enabled cycles.
               count_en = 1'b1;
               if (timer == TIMER_LAST || hit_any) state_next = CMP;
            end
         end
         CMP: begin
            busy       = 1'b1;
            state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer     <= '0;
         saturated <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= (state == CMP);
         if (clear_all) begin
            timer     <= '0;
            saturated <= 1'b0;
         end else begin
            if (count_en) timer <= timer + 1'b1;
            if (state == RUN && (hit_any || max_any)) saturated <= 1'b1;
         end
      end
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      best_idx = '0;
      best_val = count_arr[0];
      for (int i = 1; i < N; i++) begin
         if (count_arr[i] > best_val) begin
            best_val = count_arr[i];
            best_idx = WIN_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)           winner <= '0;
      else if (state == CMP)  winner <= best_idx;
   end

`ifdef RO_PAIR_RESPONSE_EN
   logic [N/2-1:0] resp_next;
   logic [N/2-1:0] resp_q;

   always_comb begin
      resp_next = '0;
      for (int k = 0; k < N/2; k++) begin
         resp_next[k] = (count_arr[2*k] > count_arr[2*k+1]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)           resp_q <= '0;
      else if (state == CMP)  resp_q <= resp_next;
   end

   assign response = resp_q;
`else
   assign response = '0;
`endif

   assign done      = done_q;
   assign fsm_state = state;

endmodule

// File: tb/tb_ro_race_counter.sv
// Directed bench for ro_race_counter: window, tie, pause, saturation, reset and restart cases.
module tb_ro_race_counter;
   import ro_race_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
`ifdef RO_PAIR_RESPONSE_EN
   localparam logic [1:0] RESP_REF = 2'b11;
`else
   localparam logic [1:0] RESP_REF = 2'b00;
`endif

   logic         clk = 1'b0;
   logic         reset_n;
   logic [N-1:0] osc_in;
   logic         start_a;
   logic         start_b;
   logic         enable;
   logic         busy_a, done_a, sat_a;
   logic         busy_b, done_b, sat_b;
   logic [N*W-1:0] counts_a, counts_b;
   logic [1:0]   winner_a, winner_b;
   logic [1:0]   resp_a, resp_b;
   state_t       state_a, state_b;

   int checks = 0;
   int errors = 0;
   int cyc;

   // Oscillator generator: toggles each channel every half_per[i] clocks (0 = hold).
   int           half_per [N];
   logic         osc_level;
   int           req_id  = 0;
   int           seen_id = 0;
   int           osc_cnt [N];
   logic [N-1:0] osc_q;

   ro_race_counter #(.N(N), .WIDTH(W), .WINDOW_CYCLES(100)) dut_a (
      .clk(clk), .reset_n(reset_n), .osc_in(osc_in), .start(start_a), .enable(enable),
      .busy(busy_a), .done(done_a), .saturated(sat_a), .counts(counts_a),
      .winner(winner_a), .response(resp_a), .fsm_state(state_a)
   );

   ro_race_counter #(.N(N), .WIDTH(W), .WINDOW_CYCLES(1000)) dut_b (
      .clk(clk), .reset_n(reset_n), .osc_in(osc_in), .start(start_b), .enable(enable),
      .busy(busy_b), .done(done_b), .saturated(sat_b), .counts(counts_b),
      .winner(winner_b), .response(resp_b), .fsm_state(state_b)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (req_id != seen_id) begin
         seen_id = req_id;
         for (int i = 0; i < N; i++) begin
            osc_cnt[i] = 0;
            osc_q[i]   = osc_level;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (half_per[i] != 0) begin
               osc_cnt[i]++;
               if (osc_cnt[i] >= half_per[i]) begin
                  osc_cnt[i] = 0;
                  osc_q[i]   = ~osc_q[i];
               end
            end
         end
      end
      osc_in = osc_q;
   end

   task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
      longint d;
      checks++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   function automatic logic [W-1:0] ch_a(input int i);
      return counts_a[i*W +: W];
   endfunction

   function automatic logic [W-1:0] ch_b(input int i);
      return counts_b[i*W +: W];
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_osc(input int h0, input int h1, input int h2, input int h3, input logic lvl);
      half_per[0] = h0;
      half_per[1] = h1;
      half_per[2] = h2;
      half_per[3] = h3;
      osc_level   = lvl;
      req_id++;
      tick(6);
   endtask

   task automatic start_pulse_a();
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
   endtask

   task automatic start_pulse_b();
      start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
   endtask

   // Counts clocks after the start edge until done; optional pause and stray start.
   task automatic wait_done_a(input int pause_at, input int pause_len, input int restart_at,
                              output int cycles);
      int n;
      logic [W-1:0] snap [N];
      n = 0;
      while (!done_a && n < 400) begin
         tick(1);
         n++;
         if (n == pause_at) begin
            enable = 1'b0;
            for (int i = 0; i < N; i++) snap[i] = ch_a(i);
         end
         if (pause_at > 0 && n == pause_at + pause_len) begin
            for (int i = 0; i < N; i++) check($sformatf("pause_hold%0d", i), ch_a(i), snap[i]);
            check("pause_busy", busy_a, 1);
            enable = 1'b1;
         end
         if (n == restart_at) start_a = 1'b1;
         if (restart_at > 0 && n == restart_at + 1) start_a = 1'b0;
      end
      check("a_done_seen", done_a, 1);
      cycles = n;
   endtask

   task automatic wait_done_b(output int cycles);
      int n;
      n = 0;
      while (!done_b && n < 2000) begin
         tick(1);
         n++;
      end
      check("b_done_seen", done_b, 1);
      cycles = n;
   endtask

   initial begin
      reset_n = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      enable  = 1'b1;
      osc_level = 1'b0;
      osc_q   = '0;
      osc_in  = '0;
      for (int i = 0; i < N; i++) begin
         half_per[i] = 0;
         osc_cnt[i]  = 0;
      end
      tick(3);

      // Reset state
      check("rst_counts", counts_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_sat", sat_a, 0);
      check("rst_winner", winner_a, 0);
      check("rst_resp", resp_a, 0);
      check("rst_state", state_a, IDLE);
      check("rst_counts_b", counts_b, 0);
      reset_n = 1'b1;
      tick(2);

      // Reference window: periods 6/8/10/12
      set_osc(3, 4, 5, 6, 1'b0);
      start_pulse_a();
      check("ref_busy", busy_a, 1);
      check("ref_state_run", state_a, RUN);
      wait_done_a(0, 0, 0, cyc);
      check("ref_cycles", cyc, 101);
      check("ref_ch0", ch_a(0), 16, 1);
      check("ref_ch1", ch_a(1), 12, 1);
      check("ref_ch2", ch_a(2), 10, 1);
      check("ref_ch3", ch_a(3), 8, 1);
      check("ref_winner", winner_a, 0);
      check("ref_sat", sat_a, 0);
      check("ref_resp", resp_a, RESP_REF);
      check("ref_done_state", state_a, DONE);
      tick(1);
      check("done_pulse_low", done_a, 0);
      check("done_busy_low", busy_a, 0);
      check("done_state_hold", state_a, DONE);
      check("done_ch2_stable", ch_a(2), 10, 1);

      // Start during RUN is ignored
      set_osc(3, 4, 5, 6, 1'b0);
      start_pulse_a();
      wait_done_a(0, 0, 50, cyc);
      check("ign_cycles", cyc, 101);
      check("ign_ch2", ch_a(2), 10, 1);

      // 50-cycle enable pause
      set_osc(3, 4, 5, 6, 1'b0);
      start_pulse_a();
      wait_done_a(20, 50, 0, cyc);
      check("pause_cycles", cyc, 151);
      check("pause_ch2", ch_a(2), 10, 1);
      check("pause_winner", winner_a, 0);

      // Tie between ch1 and ch3 (period 4)
      set_osc(4, 2, 5, 2, 1'b0);
      start_pulse_a();
      wait_done_a(0, 0, 0, cyc);
      check("tie_ch1", ch_a(1), 25);
      check("tie_ch3", ch_a(3), 25);
      check("tie_ch0", ch_a(0), 12, 1);
      check("tie_winner", winner_a, 1);
      check("tie_resp", resp_a, 0);

      // Reset in the middle of RUN
      set_osc(3, 4, 5, 6, 1'b0);
      start_pulse_a();
      tick(30);
      check("mid_busy_before", busy_a, 1);
      reset_n = 1'b0;
      #1;
      check("mid_counts", counts_a, 0);
      check("mid_busy", busy_a, 0);
      check("mid_done", done_a, 0);
      check("mid_sat", sat_a, 0);
      check("mid_winner", winner_a, 0);
      check("mid_resp", resp_a, 0);
      check("mid_state", state_a, IDLE);
      tick(2);
      reset_n = 1'b1;
      tick(1);

      // Clean run after the aborted one
      set_osc(3, 4, 5, 6, 1'b0);
      start_pulse_a();
      wait_done_a(0, 0, 0, cyc);
      check("post_cycles", cyc, 101);
      check("post_ch0", ch_a(0), 16, 1);
      check("post_ch1", ch_a(1), 12, 1);
      check("post_ch2", ch_a(2), 10, 1);
      check("post_ch3", ch_a(3), 8, 1);

      // Saturation on the long-window instance
      set_osc(3, 4, 1, 6, 1'b0);
      start_pulse_b();
      wait_done_b(cyc);
      check("sat_cycles", cyc, 510, 2);
      check("sat_before_window", cyc < 1000, 1);
      check("sat_ch2", ch_b(2), 255);
      check("sat_flag", sat_b, 1);
      check("sat_winner", winner_b, 2);
      check("sat_ch0", ch_b(0), 85, 2);
      check("sat_ch1", ch_b(1), 64, 2);
      check("sat_ch3", ch_b(3), 42, 2);
      tick(20);
      check("sat_nowrap", ch_b(2), 255);
      check("sat_hold", sat_b, 1);
      check("sat_idle_busy", busy_b, 0);

      // Start from DONE with oscillators held high
      set_osc(0, 0, 0, 0, 1'b1);
      start_pulse_a();
      check("rs_counts_clear", counts_a, 0);
      check("rs_busy", busy_a, 1);
      check("rs_done", done_a, 0);
      check("rs_state", state_a, RUN);
      wait_done_a(0, 0, 0, cyc);
      check("rs_cycles", cyc, 101);
      check("rs_counts_zero", counts_a, 0);
      check("rs_winner", winner_a, 0);
      check("rs_sat", sat_a, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
